// File: rtl/morse_key_encoder_if.sv
// Key-code handshake and keying status bundle between the keypad
// scanner side (master) and the Morse encoder (slave).
interface morse_key_encoder_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       morse_out;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output key_valid, key_code,
        input  morse_out, busy, fifo_full, overflow
    );

    modport slave (
        input  key_valid, key_code,
        output morse_out, busy, fifo_full, overflow
    );
endinterface

// File: rtl/morse_key_encoder.sv
// Morse key encoder: queues 4-bit hex key codes in a small FIFO and plays
// each one out as timed on/off keying (dot 1 unit, dash 3 units, element
// gap 1 unit, character gap 3 units). FIFO_DEPTH must be a power of two >= 2.
module morse_key_encoder #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    morse_key_encoder_if.slave bus
);
    localparam int TW = $clog2(3 * UNIT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [TW-1:0] DOT_T      = TW'(UNIT_CYCLES);
    localparam logic [TW-1:0] DASH_T     = TW'(3 * UNIT_CYCLES);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, CHAR_GAP} state_t;

    logic [3:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0] rdPtr_q;
    logic [AW-1:0] wrPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [4:0]    pattern_q;
    logic [2:0]    elemLeft_q;
    logic          morseOut_q;
    logic          busy_q;

    logic          fifoFull;
    logic          fifoEmpty;
    logic          timerDone;
    logic          pop;
    logic          push;
    logic [7:0]    headEntry;
    logic [2:0]    headLen;
    logic [4:0]    headPat;

    assign fifoFull  = (count_q == FULL_COUNT);
    assign fifoEmpty = (count_q == '0);
    assign timerDone = (timer_q == TW'(1));

    // The transmitter takes the next code either from idle or straight out
    // of a finished character gap; a push is allowed into a full FIFO only
    // when that same edge frees a slot.
    assign pop  = !fifoEmpty && ((state_q == IDLE) || (state_q == CHAR_GAP && timerDone));
    assign push = bus.key_valid && (!fifoFull || pop);

    // Code table for the FIFO head: {len, pattern}, first element in pat[4], 1 = dash.
    always_comb begin
        headEntry = 8'h00;
        case (fifoMem_q[rdPtr_q])
            4'h0:    headEntry = {3'd5, 5'b11111};
            4'h1:    headEntry = {3'd5, 5'b01111};
            4'h2:    headEntry = {3'd5, 5'b00111};
            4'h3:    headEntry = {3'd5, 5'b00011};
            4'h4:    headEntry = {3'd5, 5'b00001};
            4'h5:    headEntry = {3'd5, 5'b00000};
            4'h6:    headEntry = {3'd5, 5'b10000};
            4'h7:    headEntry = {3'd5, 5'b11000};
            4'h8:    headEntry = {3'd5, 5'b11100};
            4'h9:    headEntry = {3'd5, 5'b11110};
            4'hA:    headEntry = {3'd2, 5'b01000};
            4'hB:    headEntry = {3'd4, 5'b10000};
            4'hC:    headEntry = {3'd4, 5'b10100};
            4'hD:    headEntry = {3'd3, 5'b10000};
            4'hE:    headEntry = {3'd1, 5'b00000};
            default: headEntry = {3'd4, 5'b00100};
        endcase
    end

    assign headLen = headEntry[7:5];
    assign headPat = headEntry[4:0];

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= bus.key_code;
        end
    end

    // FIFO pointers, occupancy and the registered overflow pulse for dropped codes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= bus.key_valid && fifoFull && !pop;
        end
    end

    // Keying FSM: timer counts down to 1, and each load sets the exact cycle count of the next phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pattern_q  <= '0;
            elemLeft_q <= '0;
            morseOut_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        pattern_q  <= headPat;
                        elemLeft_q <= headLen;
                        timer_q    <= headPat[4] ? DASH_T : DOT_T;
                        morseOut_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= MARK;
                    end
                end
                MARK: begin
                    if (timerDone) begin
                        morseOut_q <= 1'b0;
                        if (elemLeft_q > 3'd1) begin
                            pattern_q  <= {pattern_q[3:0], 1'b0};
                            elemLeft_q <= elemLeft_q - 3'd1;
                            timer_q    <= DOT_T;
                            state_q    <= SPACE;
                        end else begin
                            timer_q <= DASH_T;
                            state_q <= CHAR_GAP;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                SPACE: begin
                    if (timerDone) begin
                        timer_q    <= pattern_q[4] ? DASH_T : DOT_T;
                        morseOut_q <= 1'b1;
                        state_q    <= MARK;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                CHAR_GAP: begin
                    if (timerDone) begin
                        if (pop) begin
                            pattern_q  <= headPat;
                            elemLeft_q <= headLen;
                            timer_q    <= headPat[4] ? DASH_T : DOT_T;
                            morseOut_q <= 1'b1;
                            state_q    <= MARK;
                        end else begin
                            timer_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.morse_out = morseOut_q;
    assign bus.busy      = busy_q;
    assign bus.fifo_full = fifoFull;
    assign bus.overflow  = overflow_q;
endmodule
